qpsk_demod: RTL
===============

// Module: qpsk_demod
// PURPOSE
//  Receive-side counterpart of the QPSK transmit filter. Takes one I/Q sample
//  pair per gated clock at the oversampled rate and applies an integrate-and-dump
//  matched filter over OSR samples. Slices each symbol back to (bit1, bit2) and
//  presents the bits with a one-cycle valid strobe. Sits after the channel/ADC
//  model and feeds the bit checker in loopback benches.
// PARAMETERS
//  OSR    8   samples per symbol; power of two, >= 2
//  SKIP   70  gated samples discarded after reset/sync (transmit pipeline latency)
//  ACC_W  20  accumulator width; must be >= 16 + log2(OSR) so no overflow/saturation
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous reset, active-high
//  gate      in   1      sample enable; all state frozen when 0
//  sync      in   1      synchronous realign request, overrides gate
//  real_in   in   16     signed I sample
//  imag_in   in   16     signed Q sample
//  bit1      out  1      recovered I bit
//  bit2      out  1      recovered Q bit
//  valid     out  1      one-cycle strobe: bit1/bit2/soft outputs are new
//  re_soft   out  ACC_W  signed I symbol sum (soft decision)
//  im_soft   out  ACC_W  signed Q symbol sum (soft decision)
// BEHAVIOUR
//  - Reset (rst=1, async): state=ALIGN, skip_cnt=0, phase=0, accumulators=0,
//    bit1=bit2=0, valid=0, re_soft=im_soft=0.
//  - FSM: ALIGN -> RUN when skip_cnt reaches SKIP-1 on a gated cycle. That
//    sample is discarded; the first RUN sample is the next gated one.
//    RUN -> ALIGN only on sync or rst. SKIP=0 enters RUN on the first clock
//    after reset.
//  - ALIGN: each gate=1 cycle increments skip_cnt; samples are ignored.
//  - RUN, gate=1: acc_re += sext(real_in), acc_im += sext(imag_in); phase increments mod OSR.
//  - Dump, when phase==OSR-1 on a gated cycle:
//      sum_re = acc_re + real_in, sum_im = acc_im + imag_in
//      registered next edge: re_soft=sum_re, im_soft=sum_im,
//      bit1 = sum_re<0, bit2 = sum_im<0, valid=1
//      accumulators cleared to 0; phase wraps to 0
//  - A sum of exactly zero decides as bit=0.
//  - Latency: valid rises on the edge that accepts the OSR-th sample of a
//    symbol. It is visible in the cycle after that sample is presented.
//  - valid is high for exactly one cycle, and is 0 on every non-dump cycle,
//    including gate=0 cycles.
//  - bit1/bit2/re_soft/im_soft hold their values until the next dump.
//  - gate=0: phase, skip_cnt, accumulators and FSM all hold; inputs are ignored.
//  - sync=1 (any gate value): next edge gives state=ALIGN, skip_cnt=0, phase=0,
//    accumulators=0, valid=0. bit1/bit2/soft outputs keep their last values.
//    sync on a dump cycle suppresses that dump.
//  - rst mid-symbol: the partial sum is discarded; no valid is produced for it.
//  - Arithmetic is two's complement, sign-extended to ACC_W. Full-scale -32768
//    for OSR samples must not wrap.
// TESTING
//  1 Default params. Reset, then gate=1 with real_in=+1000, imag_in=-500
//    -> first valid on cycle 78 after reset release (70 skip + 8 samples),
//    with bit1=0, bit2=1, re_soft=8000, im_soft=-4000. Valid repeats every 8 cycles.
//  2 Full scale: real_in=imag_in=-32768 for a symbol -> re_soft=im_soft=-262144,
//    bit1=bit2=1, no wrap. Also +32767 -> +262136.
//  3 gate toggling 1,0,1,0 in RUN -> valid every 16 clocks and outputs identical
//    to test 1. valid never high while gate=0.
//  4 Zero sum: the symbol alternates +5/-5 -> re_soft=0, bit1=0.
//    Then assert sync at phase 3 -> no valid for that symbol; next valid
//    arrives 70+8 gated cycles after sync.
//  5 Assert rst at phase 5 with nonzero accumulators -> all outputs 0 immediately.
//    After release, behaviour matches test 1 timing.
//  6 Loopback with the transmit filter, with SKIP tuned to its latency. Drive the
//    bit pair sequence 00,01,11,10, repeated 64 symbols -> every recovered pair
//    matches the transmitted pair, at a fixed symbol offset.

Source files
------------

// File: rtl/qpsk_demod_if.sv
// ---------------------------------------------------------------------------
// qpsk_demod_if
// Sample/bit bundle for the QPSK integrate-and-dump demodulator.
//   gate     : sample enable (source -> demod)
//   sync     : realign request, overrides gate (source -> demod)
//   real_in  : signed I sample, 16 bit (source -> demod)
//   imag_in  : signed Q sample, 16 bit (source -> demod)
//   bit1     : recovered I bit (demod -> sink)
//   bit2     : recovered Q bit (demod -> sink)
//   valid    : one-cycle strobe, bits/soft values are new (demod -> sink)
//   re_soft  : signed I symbol sum, ACC_W bit (demod -> sink)
//   im_soft  : signed Q symbol sum, ACC_W bit (demod -> sink)
// master = sample source / bit sink side, slave = the demodulator.
// ---------------------------------------------------------------------------
interface qpsk_demod_if #(
  parameter int ACC_W = 20
);
  logic                    gate;
  logic                    sync;
  logic signed [15:0]      real_in;
  logic signed [15:0]      imag_in;
  logic                    bit1;
  logic                    bit2;
  logic                    valid;
  logic signed [ACC_W-1:0] re_soft;
  logic signed [ACC_W-1:0] im_soft;

  modport master (
    output gate, sync, real_in, imag_in,
    input  bit1, bit2, valid, re_soft, im_soft
  );

  modport slave (
    input  gate, sync, real_in, imag_in,
    output bit1, bit2, valid, re_soft, im_soft
  );
endinterface

// File: rtl/qpsk_demod.sv
// ---------------------------------------------------------------------------
// qpsk_demod
// Receive-side QPSK demodulator: integrate-and-dump matched filter over OSR
// gated I/Q samples, hard slicing to (bit1, bit2) plus soft sums, with a
// one-cycle valid strobe per symbol. After reset or sync the first SKIP gated
// samples are discarded to absorb the transmit pipeline latency.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : qpsk_demod_if.slave (gate, sync, real_in, imag_in in;
//          bit1, bit2, valid, re_soft, im_soft out)
// ---------------------------------------------------------------------------
module qpsk_demod #(
  parameter int OSR   = 8,
  parameter int SKIP  = 70,
  parameter int ACC_W = 20
) (
  input  logic          clk,
  input  logic          rst,
  qpsk_demod_if.slave   bus
);

  localparam int PH_W   = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int SKIP_W = (SKIP > 2) ? $clog2(SKIP) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OSR - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic {ALIGN, RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SKIP_W-1:0]       r_skip_cnt;
  logic [PH_W-1:0]         r_phase;
  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic signed [ACC_W-1:0] r_re_soft;
  logic signed [ACC_W-1:0] r_im_soft;
  logic                    r_bit1;
  logic                    r_bit2;
  logic                    r_valid;

  logic                    w_accept;
  logic                    w_dump;
  logic signed [ACC_W-1:0] w_sum_re;
  logic signed [ACC_W-1:0] w_sum_im;

  function automatic logic signed [ACC_W-1:0] sext16(input logic signed [15:0] x);
    return {{(ACC_W-16){x[15]}}, x};
  endfunction

  // Slicer: negative sum -> 1; an exact zero decides as 0.
  function automatic logic slice(input logic signed [ACC_W-1:0] s);
    return s[ACC_W-1];
  endfunction

  // Accumulate / slice stage: combinational sum of the running total and the
  // current sample, plus FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dump      = 1'b0;
    w_sum_re    = r_acc_re + sext16(bus.real_in);
    w_sum_im    = r_acc_im + sext16(bus.imag_in);
    if (bus.sync) begin
      w_state_nxt = ALIGN;
    end else begin
      case (r_state)
        ALIGN: begin
          // SKIP=0 leaves ALIGN on the first clock regardless of gate.
          if (SKIP == 0)
            w_state_nxt = RUN;
          else if (bus.gate && (r_skip_cnt == SKIP_LAST))
            w_state_nxt = RUN;
        end
        RUN: begin
          w_accept = bus.gate;
          w_dump   = bus.gate && (r_phase == PH_LAST);
        end
        default: w_state_nxt = ALIGN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ALIGN;
    else     r_state <= w_state_nxt;
  end

  // Register stage: counters, accumulators and the dumped symbol outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skip_cnt <= '0;
      r_phase    <= '0;
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_re_soft  <= '0;
      r_im_soft  <= '0;
      r_bit1     <= 1'b0;
      r_bit2     <= 1'b0;
      r_valid    <= 1'b0;
    end else if (bus.sync) begin
      // Realign: drop any partial symbol, keep the last decided outputs.
      r_skip_cnt <= '0;
      r_phase    <= '0;
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_dump;
      if (r_state == ALIGN && bus.gate) begin
        if (w_state_nxt == RUN) r_skip_cnt <= '0;
        else                    r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
      end
      if (w_dump) begin
        r_re_soft <= w_sum_re;
        r_im_soft <= w_sum_im;
        r_bit1    <= slice(w_sum_re);
        r_bit2    <= slice(w_sum_im);
        r_acc_re  <= '0;
        r_acc_im  <= '0;
        r_phase   <= '0;
      end else if (w_accept) begin
        r_acc_re  <= w_sum_re;
        r_acc_im  <= w_sum_im;
        r_phase   <= r_phase + PH_W'(1);
      end
    end
  end

  assign bus.bit1    = r_bit1;
  assign bus.bit2    = r_bit2;
  assign bus.valid   = r_valid;
  assign bus.re_soft = r_re_soft;
  assign bus.im_soft = r_im_soft;

endmodule
